input_tile_scheduler: RTL and testbench

//  Sequences the Winograd input-transform controller across all input channels of one layer.

---
 rtl/input_tile_scheduler_pkg.sv | 18 +
 rtl/input_tile_scheduler_if.sv | 42 ++++
 rtl/input_tile_scheduler_tile_drain_counter.sv | 58 +++++
 rtl/input_tile_scheduler.sv | 163 ++++++++++++++++
 tb/tb_input_tile_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_tile_scheduler_pkg.sv
// Shared types for the Winograd input-tile scheduler: FSM state encoding and
// the size of the 8-bit tile address space a whole layer must fit in.
package input_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWaitPe,
    StPrep,
    StStream,
    StDrain,
    StNext,
    StFin
  } sched_state_e;

  localparam int unsigned AddrSpace = 256;

endpackage

// File: rtl/input_tile_scheduler_if.sv
// Handshake bundle between the main controller / transform path and the
// input-tile scheduler. The slave modport is the scheduler's view.
interface input_tile_scheduler_if #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DIM_W = 8
);

  logic             start_i;
  logic [ID_W:0]    num_channels_i;
  logic [DIM_W-1:0] block_width_i;
  logic [DIM_W-1:0] block_height_i;
  logic             size_type_i;
  logic             pe_ready_i;
  logic             loop_finished_i;
  logic             data_valid_i_1;
  logic             data_valid_i_2;
  logic [ID_W-1:0]  input_id_o;
  logic             input_prepare_o;
  logic [DIM_W-1:0] block_width_o;
  logic [DIM_W-1:0] block_height_o;
  logic             size_type_o;
  logic             busy_o;
  logic             channel_done_o;
  logic             done_o;
  logic             err_o;
  logic [DIM_W-1:0] tile_cnt_o;

  modport master (
    output start_i, num_channels_i, block_width_i, block_height_i, size_type_i,
           pe_ready_i, loop_finished_i, data_valid_i_1, data_valid_i_2,
    input  input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o,
           busy_o, channel_done_o, done_o, err_o, tile_cnt_o
  );

  modport slave (
    input  start_i, num_channels_i, block_width_i, block_height_i, size_type_i,
           pe_ready_i, loop_finished_i, data_valid_i_1, data_valid_i_2,
    output input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o,
           busy_o, channel_done_o, done_o, err_o, tile_cnt_o
  );

endinterface

// File: rtl/input_tile_scheduler_tile_drain_counter.sv
// Per-channel tile counter taking up to two tiles per cycle (saturating), plus
// an idle timer that counts consecutive valid-free cycles while enabled.
module input_tile_scheduler_tile_drain_counter #(
  parameter int unsigned DIM_W         = 8,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  input  logic             tmo_en_i,
  input  logic             valid1_i,
  input  logic             valid2_i,
  output logic [DIM_W-1:0] cnt_o,
  output logic [DIM_W-1:0] cnt_nxt_o,
  output logic             timeout_o
);

  localparam int unsigned     TmoW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DRAIN_TIMEOUT - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
  localparam logic [DIM_W:0]  CntMax  = {1'b0, {DIM_W{1'b1}}};

  logic [DIM_W-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [DIM_W:0]   sum;
  logic [1:0]       adds;
  logic             any_valid;

  always_comb begin
    any_valid = valid1_i | valid2_i;
    adds      = cnt_en_i ? ({1'b0, valid1_i} + {1'b0, valid2_i}) : 2'd0;
    // clr_i restarts from zero but still takes this cycle's tiles
    sum       = (clr_i ? '0 : {1'b0, cnt_q}) + {{(DIM_W-1){1'b0}}, adds};
    cnt_d     = (sum > CntMax) ? CntMax[DIM_W-1:0] : sum[DIM_W-1:0];

    timeout_o = tmo_en_i && !any_valid && (tmo_q == TmoLast);
    if (!tmo_en_i || any_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/input_tile_scheduler.sv
// Walks the Winograd input transform over every channel of a layer: checks the
// latched config, launches each channel, then waits for its tiles to drain.
module input_tile_scheduler
  import input_tile_scheduler_pkg::*;
#(
  parameter int unsigned ID_W          = 4,
  parameter int unsigned DIM_W         = 8,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  input_tile_scheduler_if.slave bus
);

  localparam int unsigned     TotW  = 2 * DIM_W + ID_W + 1;
  localparam logic [ID_W:0]   MaxCh = {1'b1, {ID_W{1'b0}}};
  localparam logic [ID_W:0]   ChOne = (ID_W + 1)'(1);
  localparam logic [ID_W-1:0] IdOne = ID_W'(1);

  sched_state_e state_q, state_d;
  logic [ID_W:0]      num_ch_q, num_ch_d;
  logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
  logic               size_q, size_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               cnt_clr, cnt_en, tmo_en, timeout;
  logic [DIM_W-1:0]   tile_cnt, tile_cnt_nxt;
  logic [2*DIM_W-1:0] bcnt, cnt_nxt_ext;
  logic [TotW-1:0]    total;
  logic               cfg_err, any_valid, last_ch;

  assign any_valid   = bus.data_valid_i_1 | bus.data_valid_i_2;
  assign bcnt        = {{DIM_W{1'b0}}, width_q} * {{DIM_W{1'b0}}, height_q};
  assign total       = {{(ID_W + 1){1'b0}}, bcnt} * {{(2 * DIM_W){1'b0}}, num_ch_q};
  assign cnt_nxt_ext = {{DIM_W{1'b0}}, tile_cnt_nxt};
  assign last_ch     = ({1'b0, id_q} == (num_ch_q - ChOne));

  // Per-channel tile block must fit the counter and the whole layer the address space
  assign cfg_err = (width_q == '0) || (height_q == '0) || (num_ch_q == '0) ||
                   (num_ch_q > MaxCh) || (|bcnt[2*DIM_W-1:DIM_W]) ||
                   (total > TotW'(AddrSpace));

  always_comb begin
    state_d  = state_q;
    num_ch_d = num_ch_q;
    width_d  = width_q;
    height_d = height_q;
    size_d   = size_q;
    err_d    = err_q;
    id_d     = id_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    tmo_en   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          num_ch_d = bus.num_channels_i;
          width_d  = bus.block_width_i;
          height_d = bus.block_height_i;
          size_d   = bus.size_type_i;
          err_d    = 1'b0;
          id_d     = '0;
          cnt_clr  = 1'b1;
          state_d  = StCheck;
        end else if (any_valid) begin
          err_d = 1'b1;
        end
      end
      StCheck: begin
        cnt_en = 1'b1;
        if (cfg_err) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StWaitPe;
        end
      end
      StWaitPe: begin
        if (any_valid) err_d = 1'b1;
        if (bus.pe_ready_i) state_d = StPrep;
      end
      StPrep: begin
        cnt_en  = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        cnt_en = 1'b1;
        if (bus.loop_finished_i) state_d = StDrain;
      end
      StDrain: begin
        cnt_en = 1'b1;
        tmo_en = 1'b1;
        if (cnt_nxt_ext == bcnt) begin
          state_d = StNext;
        end else if ((cnt_nxt_ext > bcnt) || timeout) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StNext: begin
        // Tiles landing here belong to the next channel
        cnt_clr = 1'b1;
        cnt_en  = 1'b1;
        id_d    = id_q + IdOne;
        state_d = last_ch ? StFin : StWaitPe;
      end
      StFin: begin
        if (any_valid) err_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      num_ch_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      size_q   <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      num_ch_q <= num_ch_d;
      width_q  <= width_d;
      height_q <= height_d;
      size_q   <= size_d;
      err_q    <= err_d;
      id_q     <= id_d;
    end
  end

  input_tile_scheduler_tile_drain_counter #(
    .DIM_W         (DIM_W),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_counter (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (cnt_clr),
    .cnt_en_i  (cnt_en),
    .tmo_en_i  (tmo_en),
    .valid1_i  (bus.data_valid_i_1),
    .valid2_i  (bus.data_valid_i_2),
    .cnt_o     (tile_cnt),
    .cnt_nxt_o (tile_cnt_nxt),
    .timeout_o (timeout)
  );

  assign bus.input_id_o      = id_q;
  assign bus.input_prepare_o = (state_q == StPrep);
  assign bus.block_width_o   = width_q;
  assign bus.block_height_o  = height_q;
  assign bus.size_type_o     = size_q;
  assign bus.busy_o          = (state_q != StIdle);
  assign bus.channel_done_o  = (state_q == StNext);
  assign bus.done_o          = (state_q == StFin);
  assign bus.err_o           = err_q;
  assign bus.tile_cnt_o      = tile_cnt;

endmodule

// File: tb/tb_input_tile_scheduler.sv
// Directed and randomized bench for input_tile_scheduler; expectations come
// from the layer/channel rules applied to what the bench itself drives.
module tb_input_tile_scheduler;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned DIM_W = 8;
  localparam int unsigned TMO   = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_tile_scheduler_if #(.ID_W(ID_W), .DIM_W(DIM_W)) ifc ();

  input_tile_scheduler #(
    .ID_W          (ID_W),
    .DIM_W         (DIM_W),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mon_prep = 0;
  int mon_chdone = 0;
  int mon_done = 0;

  always @(negedge clk) begin
    if (ifc.input_prepare_o === 1'b1) mon_prep++;
    if (ifc.channel_done_o === 1'b1) mon_chdone++;
    if (ifc.done_o === 1'b1) mon_done++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic bit cfg_legal(input int n, input int w, input int h);
    return (w > 0) && (h > 0) && (n >= 1) && (n <= (1 << ID_W)) &&
           (w * h <= (1 << DIM_W) - 1) && (w * h * n <= 256);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, ifc.busy_o, 0);
    check({tag, "_prep"}, ifc.input_prepare_o, 0);
    check({tag, "_id"}, ifc.input_id_o, 0);
    check({tag, "_cnt"}, ifc.tile_cnt_o, 0);
    check({tag, "_err"}, ifc.err_o, 0);
    check({tag, "_done"}, ifc.done_o, 0);
    check({tag, "_chdone"}, ifc.channel_done_o, 0);
    check({tag, "_bw"}, ifc.block_width_o, 0);
    check({tag, "_bh"}, ifc.block_height_o, 0);
    check({tag, "_st"}, ifc.size_type_o, 0);
  endtask

  task automatic start_layer(input int n, input int w, input int h);
    logic st;
    st = 1'($urandom_range(1, 0));
    ifc.num_channels_i = n[ID_W:0];
    ifc.block_width_i  = w[DIM_W-1:0];
    ifc.block_height_i = h[DIM_W-1:0];
    ifc.size_type_i    = st;
    ifc.start_i        = 1'b1;
    step();
    ifc.start_i = 1'b0;
    check("busy_on_start", ifc.busy_o, 1);
    check("err_cleared", ifc.err_o, 0);
    check("cnt_cleared", ifc.tile_cnt_o, 0);
    check("bw_latched", ifc.block_width_o, w[DIM_W-1:0]);
    check("bh_latched", ifc.block_height_o, h[DIM_W-1:0]);
    check("st_latched", ifc.size_type_o, st);
  endtask

  task automatic wait_prep(input int id);
    int cyc = 0;
    while (ifc.input_prepare_o !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("prep_seen", ifc.input_prepare_o, 1);
    check("prep_id", ifc.input_id_o, id);
  endtask

  task automatic run_channel(input int id, input int bcnt, input bit rnd_ready);
    int  sent = 0;
    int  cyc  = 0;
    int  lf_at;
    bit  lf_done = 1'b0;
    if (rnd_ready) begin
      ifc.pe_ready_i = 1'b0;
      repeat ($urandom_range(4, 0)) begin
        step();
        check("no_prep_unready", ifc.input_prepare_o, 0);
      end
      ifc.pe_ready_i = 1'b1;
    end
    wait_prep(id);
    step();
    lf_at = int'($urandom_range(bcnt, 0));
    while ((sent < bcnt || !lf_done) && cyc < 2000) begin
      check("tile_cnt", ifc.tile_cnt_o, sent);
      ifc.data_valid_i_1  = 1'b0;
      ifc.data_valid_i_2  = 1'b0;
      ifc.loop_finished_i = 1'b0;
      if (!lf_done && sent >= lf_at && $urandom_range(1, 0) == 1) begin
        ifc.loop_finished_i = 1'b1;
        lf_done = 1'b1;
      end
      if (sent < bcnt && $urandom_range(3, 0) != 0) begin
        if (bcnt - sent >= 2 && $urandom_range(1, 0) == 1) begin
          ifc.data_valid_i_1 = 1'b1;
          ifc.data_valid_i_2 = 1'b1;
          sent += 2;
        end else if ($urandom_range(1, 0) == 1) begin
          ifc.data_valid_i_1 = 1'b1;
          sent++;
        end else begin
          ifc.data_valid_i_2 = 1'b1;
          sent++;
        end
      end
      step();
      cyc++;
    end
    ifc.data_valid_i_1  = 1'b0;
    ifc.data_valid_i_2  = 1'b0;
    ifc.loop_finished_i = 1'b0;
    cyc = 0;
    while (ifc.channel_done_o !== 1'b1 && cyc < 5) begin
      step();
      cyc++;
    end
    check("chdone_seen", ifc.channel_done_o, 1);
    check("chdone_cnt", ifc.tile_cnt_o, bcnt);
    check("id_stable", ifc.input_id_o, id);
  endtask

  task automatic wait_done(input int exp_err);
    int cyc = 0;
    while (ifc.done_o !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    check("done_seen", ifc.done_o, 1);
    check("err_final", ifc.err_o, exp_err);
    step();
    check("busy_after_done", ifc.busy_o, 0);
  endtask

  task automatic run_layer(input int n, input int w, input int h, input bit rnd_ready);
    int p0 = mon_prep;
    int c0 = mon_chdone;
    int d0 = mon_done;
    bit legal = cfg_legal(n, w, h);
    start_layer(n, w, h);
    if (legal) begin
      for (int ch = 0; ch < n; ch++) run_channel(ch, w * h, rnd_ready);
      wait_done(0);
    end else begin
      step();
      check("cfg_err_done_lat", ifc.done_o, 1);
      check("cfg_err_flag", ifc.err_o, 1);
      step();
      check("cfg_err_busy", ifc.busy_o, 0);
    end
    check("prep_count", mon_prep - p0, legal ? n : 0);
    check("chdone_count", mon_chdone - c0, legal ? n : 0);
    check("done_count", mon_done - d0, 1);
  endtask

  initial begin
    int p0, d0;
    reset = 1'b0;
    ifc.start_i = 1'b0;
    ifc.num_channels_i = '0;
    ifc.block_width_i = '0;
    ifc.block_height_i = '0;
    ifc.size_type_i = 1'b0;
    ifc.pe_ready_i = 1'b1;
    ifc.loop_finished_i = 1'b0;
    ifc.data_valid_i_1 = 1'b0;
    ifc.data_valid_i_2 = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b1;
    step();

    // Basic two-channel layer, then config errors
    run_layer(2, 2, 2, 1'b0);
    run_layer(1, 0, 2, 1'b0);
    run_layer(1, 16, 16, 1'b0);
    run_layer(3, 10, 10, 1'b0);
    run_layer(17, 1, 1, 1'b0);
    run_layer(1, 15, 17, 1'b0);
    run_layer(16, 4, 4, 1'b0);

    // PE not ready for 5 cycles; start while busy must be ignored
    p0 = mon_prep;
    d0 = mon_done;
    ifc.pe_ready_i = 1'b0;
    start_layer(1, 2, 2);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ifc.block_width_i = 8'd7;
        ifc.start_i = 1'b1;
      end
      step();
      ifc.start_i = 1'b0;
      check("hold_no_prep", ifc.input_prepare_o, 0);
    end
    check("busy_start_ignored", ifc.block_width_o, 2);
    check("hold_prep_count", mon_prep - p0, 0);
    ifc.pe_ready_i = 1'b1;
    run_channel(0, 4, 1'b0);
    wait_done(0);
    check("hold_done_count", mon_done - d0, 1);

    // Short channel: only 3 of 4 tiles after loop_finished -> drain timeout
    d0 = mon_done;
    start_layer(1, 2, 2);
    wait_prep(0);
    step();
    ifc.loop_finished_i = 1'b1;
    step();
    ifc.loop_finished_i = 1'b0;
    repeat (3) begin
      ifc.data_valid_i_1 = 1'b1;
      step();
    end
    ifc.data_valid_i_1 = 1'b0;
    check("tmo_cnt3", ifc.tile_cnt_o, 3);
    for (int i = 1; i <= int'(TMO); i++) begin
      step();
      if (i == int'(TMO) - 1) check("tmo_not_yet", ifc.err_o, 0);
    end
    check("tmo_err", ifc.err_o, 1);
    check("tmo_done", ifc.done_o, 1);
    check("tmo_chdone", ifc.channel_done_o, 0);
    step();
    check("tmo_busy", ifc.busy_o, 0);
    check("tmo_err_sticky", ifc.err_o, 1);
    check("tmo_done_count", mon_done - d0, 1);

    // Reset during STREAM of channel 1
    d0 = mon_done;
    start_layer(2, 2, 2);
    run_channel(0, 4, 1'b0);
    wait_prep(1);
    step();
    ifc.data_valid_i_1 = 1'b1;
    step();
    ifc.data_valid_i_1 = 1'b0;
    check("pre_reset_cnt", ifc.tile_cnt_o, 1);
    reset = 1'b0;
    step();
    check_all_zero("midreset");
    reset = 1'b1;
    step();
    check("midreset_no_done", mon_done - d0, 0);

    // Stray tile while idle flags an error without counting
    ifc.data_valid_i_2 = 1'b1;
    step();
    ifc.data_valid_i_2 = 1'b0;
    check("idle_valid_err", ifc.err_o, 1);
    check("idle_valid_cnt", ifc.tile_cnt_o, 0);
    run_layer(1, 2, 2, 1'b0);

    // Randomized layers against the config/drain rules
    for (int it = 0; it < 12; it++) begin
      int n, w, h;
      n = int'($urandom_range(4, 1));
      if (it % 3 == 2) begin
        w = int'($urandom_range(20, 0));
        h = int'($urandom_range(20, 10));
      end else begin
        w = int'($urandom_range(6, 1));
        h = int'($urandom_range(6, 1));
      end
      run_layer(n, w, h, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
